clock_time_ctrl: RTL and testbench

Time-keeping and user-setting controller directly upstream of `display_control`.
- Holds the running HH:MM:SS time and the HH:MM alarm as split BCD digits.
- Runs the mode state machine and the edit cursor from debounced key pulses.
- Drives the `mode`, `pos`, time and alarm digit inputs of `display_control` directly, and raises a one-cycle alarm pulse for the buzzer logic.

---
 rtl/clock_pkg.sv | 51 +++++
 rtl/bcd_time_counter.sv | 116 +++++++++++
 rtl/clock_time_ctrl.sv | 154 +++++++++++++++
 tb/tb_clock_time_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clock_pkg
//  Description : Shared mode codes, cursor codes, BCD digit limits and
//                digit-step helpers for the clock controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package clock_pkg;

    // Mode encoding; 2'b11 is never entered on purpose
    localparam logic [1:0] NORMAL_MODE    = 2'b00;
    localparam logic [1:0] CLOCK_SET_MODE = 2'b01;
    localparam logic [1:0] ALARM_SET_MODE = 2'b10;
    localparam logic [1:0] MODE_ILLEGAL   = 2'b11;

    // Cursor encoding
    localparam logic [2:0] POS_NONE = 3'd0;
    localparam logic [2:0] POS_HT   = 3'd1;
    localparam logic [2:0] POS_HO   = 3'd2;
    localparam logic [2:0] POS_MT   = 3'd3;
    localparam logic [2:0] POS_MO   = 3'd4;
    localparam logic [2:0] POS_ST   = 3'd5;
    localparam logic [2:0] POS_SO   = 3'd6;

    // Digit limits
    localparam logic [3:0] ONES_MAX         = 4'd9;
    localparam logic [2:0] MIN_TENS_MAX     = 3'd5;
    localparam logic [2:0] SEC_TENS_MAX     = 3'd5;
    localparam logic [1:0] HOUR_TENS_MAX    = 2'd2;
    localparam logic [3:0] HOUR_ONES_MAX_HI = 4'd3;

    // Wrap-around step of a single digit, no carry out
    function automatic logic [3:0] step4(input logic [3:0] d, input logic [3:0] max);
        return (d >= max) ? 4'd0 : d + 4'd1;
    endfunction

    function automatic logic [2:0] step3(input logic [2:0] d, input logic [2:0] max);
        return (d >= max) ? 3'd0 : d + 3'd1;
    endfunction

    function automatic logic [1:0] step2(input logic [1:0] d, input logic [1:0] max);
        return (d >= max) ? 2'd0 : d + 2'd1;
    endfunction

    // Hour ones may only reach 3 once hour tens is 2
    function automatic logic [3:0] hour_ones_max(input logic [1:0] ht);
        return (ht == HOUR_TENS_MAX) ? HOUR_ONES_MAX_HI : ONES_MAX;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_time_counter.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_time_counter
//  Description : Six BCD time digits with a 1 Hz carry chain and a per-digit
//                increment port. Also exposes the HH:MM the next tick would
//                produce so the alarm compare can be registered alongside it.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_time_counter
    import clock_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_tick,
    input  logic       i_inc,
    input  logic [2:0] i_sel,
    output logic [1:0] o_hour_tens,
    output logic [3:0] o_hour_ones,
    output logic [2:0] o_min_tens,
    output logic [3:0] o_min_ones,
    output logic [2:0] o_sec_tens,
    output logic [3:0] o_sec_ones,
    output logic [1:0] o_nxt_hour_tens,
    output logic [3:0] o_nxt_hour_ones,
    output logic [2:0] o_nxt_min_tens,
    output logic [3:0] o_nxt_min_ones,
    output logic       o_sec_wrap
);

    logic [1:0] r_ht;
    logic [3:0] r_ho;
    logic [2:0] r_mt;
    logic [3:0] r_mo;
    logic [2:0] r_st;
    logic [3:0] r_so;

    logic       w_so_c, w_st_c, w_mo_c, w_mt_c;
    logic [1:0] w_t_ht;
    logic [3:0] w_t_ho, w_t_mo, w_t_so;
    logic [2:0] w_t_mt, w_t_st;
    logic [1:0] w_ht_step;

    assign w_ht_step = step2(r_ht, HOUR_TENS_MAX);

    // Tick carry chain: value of every digit one second from now
    always_comb begin
        w_so_c = (r_so == ONES_MAX);
        w_st_c = w_so_c && (r_st == SEC_TENS_MAX);
        w_mo_c = w_st_c && (r_mo == ONES_MAX);
        w_mt_c = w_mo_c && (r_mt == MIN_TENS_MAX);
        w_t_so = step4(r_so, ONES_MAX);
        w_t_st = w_so_c ? step3(r_st, SEC_TENS_MAX) : r_st;
        w_t_mo = w_st_c ? step4(r_mo, ONES_MAX) : r_mo;
        w_t_mt = w_mo_c ? step3(r_mt, MIN_TENS_MAX) : r_mt;
        w_t_ht = r_ht;
        w_t_ho = r_ho;
        if (w_mt_c) begin
            if ((r_ht == HOUR_TENS_MAX) && (r_ho == HOUR_ONES_MAX_HI)) begin
                w_t_ht = 2'd0;
                w_t_ho = 4'd0;
            end else if (r_ho == ONES_MAX) begin
                w_t_ht = r_ht + 2'd1;
                w_t_ho = 4'd0;
            end else begin
                w_t_ho = r_ho + 4'd1;
            end
        end
    end

    // Digit registers: tick advances the whole time, inc bumps one digit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ht <= 2'd0;
            r_ho <= 4'd0;
            r_mt <= 3'd0;
            r_mo <= 4'd0;
            r_st <= 3'd0;
            r_so <= 4'd0;
        end else if (i_tick) begin
            r_ht <= w_t_ht;
            r_ho <= w_t_ho;
            r_mt <= w_t_mt;
            r_mo <= w_t_mo;
            r_st <= w_t_st;
            r_so <= w_t_so;
        end else if (i_inc) begin
            case (i_sel)
                POS_HT: begin
                    r_ht <= w_ht_step;
                    if ((w_ht_step == HOUR_TENS_MAX) && (r_ho > HOUR_ONES_MAX_HI))
                        r_ho <= HOUR_ONES_MAX_HI;
                end
                POS_HO:  r_ho <= step4(r_ho, hour_ones_max(r_ht));
                POS_MT:  r_mt <= step3(r_mt, MIN_TENS_MAX);
                POS_MO:  r_mo <= step4(r_mo, ONES_MAX);
                POS_ST:  r_st <= step3(r_st, SEC_TENS_MAX);
                POS_SO:  r_so <= step4(r_so, ONES_MAX);
                default: ;
            endcase
        end
    end

    assign o_hour_tens     = r_ht;
    assign o_hour_ones     = r_ho;
    assign o_min_tens      = r_mt;
    assign o_min_ones      = r_mo;
    assign o_sec_tens      = r_st;
    assign o_sec_ones      = r_so;
    assign o_nxt_hour_tens = w_t_ht;
    assign o_nxt_hour_ones = w_t_ho;
    assign o_nxt_min_tens  = w_t_mt;
    assign o_nxt_min_ones  = w_t_mo;
    assign o_sec_wrap      = w_st_c;

endmodule
`default_nettype wire

// File: rtl/clock_time_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : clock_time_ctrl
//  Description : Mode FSM, edit cursor, alarm registers and alarm pulse for
//                the clock; time digits live in bcd_time_counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module clock_time_ctrl
    import clock_pkg::*;
#(
    parameter logic [1:0] ALARM_RST_HT = 2'd0,
    parameter logic [3:0] ALARM_RST_HO = 4'd7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       key_mode,
    input  logic       key_next,
    input  logic       key_inc,
    input  logic       alarm_en,
    output logic [1:0] mode,
    output logic [2:0] pos,
    output logic [1:0] hour_tens,
    output logic [3:0] hour_ones,
    output logic [2:0] min_tens,
    output logic [3:0] min_ones,
    output logic [2:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [1:0] alarm_hour_tens,
    output logic [3:0] alarm_hour_ones,
    output logic [2:0] alarm_minute_tens,
    output logic [3:0] alarm_minute_ones,
    output logic       alarm_hit
);

    logic [1:0] r_mode;
    logic [2:0] r_pos;
    logic [1:0] r_aht;
    logic [3:0] r_aho;
    logic [2:0] r_amt;
    logic [3:0] r_amo;
    logic       r_alarm_hit;

    logic       w_inc_eff, w_inc_clock, w_inc_alarm, w_tick_run;
    logic [1:0] w_aht_step;
    logic [1:0] w_nxt_ht;
    logic [3:0] w_nxt_ho;
    logic [2:0] w_nxt_mt;
    logic [3:0] w_nxt_mo;
    logic       w_sec_wrap;
    logic       w_alarm_match;

    // key_mode beats key_next beats key_inc; ticks never run in CLOCK_SET
    assign w_inc_eff   = key_inc && !key_mode && !key_next;
    assign w_inc_clock = w_inc_eff && (r_mode == CLOCK_SET_MODE);
    assign w_inc_alarm = w_inc_eff && (r_mode == ALARM_SET_MODE);
    assign w_tick_run  = tick_1hz && ((r_mode == NORMAL_MODE) || (r_mode == ALARM_SET_MODE));
    assign w_aht_step  = step2(r_aht, HOUR_TENS_MAX);

    // This tick lands on HH:MM:00 equal to the alarm
    assign w_alarm_match = alarm_en && (r_mode == NORMAL_MODE) && w_tick_run && w_sec_wrap
                           && (w_nxt_ht == r_aht) && (w_nxt_ho == r_aho)
                           && (w_nxt_mt == r_amt) && (w_nxt_mo == r_amo);

    bcd_time_counter u_time (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_tick          (w_tick_run),
        .i_inc           (w_inc_clock),
        .i_sel           (r_pos),
        .o_hour_tens     (hour_tens),
        .o_hour_ones     (hour_ones),
        .o_min_tens      (min_tens),
        .o_min_ones      (min_ones),
        .o_sec_tens      (sec_tens),
        .o_sec_ones      (sec_ones),
        .o_nxt_hour_tens (w_nxt_ht),
        .o_nxt_hour_ones (w_nxt_ho),
        .o_nxt_min_tens  (w_nxt_mt),
        .o_nxt_min_ones  (w_nxt_mo),
        .o_sec_wrap      (w_sec_wrap)
    );

    // Mode FSM and edit cursor
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode <= NORMAL_MODE;
            r_pos  <= POS_NONE;
        end else if (r_mode == MODE_ILLEGAL) begin
            r_mode <= NORMAL_MODE;
            r_pos  <= POS_NONE;
        end else if (key_mode) begin
            case (r_mode)
                NORMAL_MODE: begin
                    r_mode <= CLOCK_SET_MODE;
                    r_pos  <= POS_HT;
                end
                CLOCK_SET_MODE: begin
                    r_mode <= ALARM_SET_MODE;
                    r_pos  <= POS_HT;
                end
                default: begin
                    r_mode <= NORMAL_MODE;
                    r_pos  <= POS_NONE;
                end
            endcase
        end else if (key_next) begin
            if (r_mode == CLOCK_SET_MODE)
                r_pos <= (r_pos >= POS_SO) ? POS_HT : r_pos + 3'd1;
            else if (r_mode == ALARM_SET_MODE)
                r_pos <= (r_pos >= POS_MO) ? POS_HT : r_pos + 3'd1;
        end
    end

    // Alarm HH:MM digits, edited only in ALARM_SET
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_aht <= ALARM_RST_HT;
            r_aho <= ALARM_RST_HO;
            r_amt <= 3'd0;
            r_amo <= 4'd0;
        end else if (w_inc_alarm) begin
            case (r_pos)
                POS_HT: begin
                    r_aht <= w_aht_step;
                    if ((w_aht_step == HOUR_TENS_MAX) && (r_aho > HOUR_ONES_MAX_HI))
                        r_aho <= HOUR_ONES_MAX_HI;
                end
                POS_HO:  r_aho <= step4(r_aho, hour_ones_max(r_aht));
                POS_MT:  r_amt <= step3(r_amt, MIN_TENS_MAX);
                POS_MO:  r_amo <= step4(r_amo, ONES_MAX);
                default: ;
            endcase
        end
    end

    // One-cycle alarm pulse, aligned with the matching time on the outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_alarm_hit <= 1'b0;
        else
            r_alarm_hit <= w_alarm_match;
    end

    assign mode              = r_mode;
    assign pos               = r_pos;
    assign alarm_hour_tens   = r_aht;
    assign alarm_hour_ones   = r_aho;
    assign alarm_minute_tens = r_amt;
    assign alarm_minute_ones = r_amo;
    assign alarm_hit         = r_alarm_hit;

endmodule
`default_nettype wire

// File: tb/tb_clock_time_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clock_time_ctrl
//  Description : Directed self-checking bench for clock_time_ctrl with an
//                expectation queue.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_clock_time_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       key_mode = 1'b0;
    logic       key_next = 1'b0;
    logic       key_inc = 1'b0;
    logic       alarm_en = 1'b0;
    logic [1:0] mode;
    logic [2:0] pos;
    logic [1:0] hour_tens;
    logic [3:0] hour_ones;
    logic [2:0] min_tens;
    logic [3:0] min_ones;
    logic [2:0] sec_tens;
    logic [3:0] sec_ones;
    logic [1:0] alarm_hour_tens;
    logic [3:0] alarm_hour_ones;
    logic [2:0] alarm_minute_tens;
    logic [3:0] alarm_minute_ones;
    logic       alarm_hit;

    clock_time_ctrl #(
        .ALARM_RST_HT (2'd0),
        .ALARM_RST_HO (4'd7)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .tick_1hz          (tick_1hz),
        .key_mode          (key_mode),
        .key_next          (key_next),
        .key_inc           (key_inc),
        .alarm_en          (alarm_en),
        .mode              (mode),
        .pos               (pos),
        .hour_tens         (hour_tens),
        .hour_ones         (hour_ones),
        .min_tens          (min_tens),
        .min_ones          (min_ones),
        .sec_tens          (sec_tens),
        .sec_ones          (sec_ones),
        .alarm_hour_tens   (alarm_hour_tens),
        .alarm_hour_ones   (alarm_hour_ones),
        .alarm_minute_tens (alarm_minute_tens),
        .alarm_minute_ones (alarm_minute_ones),
        .alarm_hit         (alarm_hit)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [38:0] v;
    } exp_t;

    exp_t        q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          pos_seq[7] = '{2, 3, 4, 5, 6, 1, 2};
    logic [38:0] obs;

    assign obs = {mode, pos, hour_tens, hour_ones, min_tens, min_ones, sec_tens, sec_ones,
                  alarm_hour_tens, alarm_hour_ones, alarm_minute_tens, alarm_minute_ones,
                  alarm_hit};

    function automatic string fmt(input logic [38:0] v);
        return $sformatf("mode=%0d pos=%0d time=%0d%0d:%0d%0d:%0d%0d alarm=%0d%0d:%0d%0d hit=%0d",
                         v[38:37], v[36:34], v[33:32], v[31:28], v[27:25], v[24:21],
                         v[20:18], v[17:14], v[13:12], v[11:8], v[7:5], v[4:1], v[0]);
    endfunction

    // Expected state given in decimal HH/MM/SS, split into BCD here
    task automatic expect_st(input string tag, input int md, input int p,
                             input int hh, input int mm, input int ss,
                             input int ahh, input int amm, input int hit);
        exp_t e;
        e.tag = tag;
        e.v = {2'(md), 3'(p), 2'(hh / 10), 4'(hh % 10), 3'(mm / 10), 4'(mm % 10),
               3'(ss / 10), 4'(ss % 10), 2'(ahh / 10), 4'(ahh % 10), 3'(amm / 10),
               4'(amm % 10), 1'(hit)};
        q.push_back(e);
    endtask

    task automatic check();
        exp_t e;
        vectors++;
        if (q.size() == 0) begin
            miscompares++;
            $display("FAIL scoreboard: observed %s, required a queued expectation", fmt(obs));
        end else begin
            e = q.pop_front();
            assert (obs === e.v) else begin
                miscompares++;
                $error("FAIL %s: observed %s, expected %s", e.tag, fmt(obs), fmt(e.v));
            end
        end
    endtask

    // One-cycle input pulse; outputs are settled at the closing negedge
    task automatic drive(input logic km, input logic kn, input logic ki, input logic tk);
        @(negedge clk);
        key_mode = km;
        key_next = kn;
        key_inc  = ki;
        tick_1hz = tk;
        @(negedge clk);
        key_mode = 1'b0;
        key_next = 1'b0;
        key_inc  = 1'b0;
        tick_1hz = 1'b0;
    endtask

    task automatic inc_n(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic nxt_n(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        expect_st("reset", 0, 0, 0, 0, 0, 7, 0, 0);
        check();
        rst_n = 1'b1;

        // Mode cycle and cursor walk
        expect_st("mode_to_clock_set", 1, 1, 0, 0, 0, 7, 0, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0); check();
        for (int i = 0; i < 7; i++) begin
            expect_st($sformatf("cursor_step_%0d", i), 1, pos_seq[i], 0, 0, 0, 7, 0, 0);
            drive(1'b0, 1'b1, 1'b0, 1'b0); check();
        end
        expect_st("mode_to_alarm_set", 2, 1, 0, 0, 0, 7, 0, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0); check();
        expect_st("mode_to_normal", 0, 0, 0, 0, 0, 7, 0, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0); check();

        // Midnight rollover from 23:59:58
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        expect_st("preset_235958", 1, 6, 23, 59, 58, 7, 0, 0);
        inc_n(2); nxt_n(1); inc_n(3); nxt_n(1); inc_n(5); nxt_n(1);
        inc_n(9); nxt_n(1); inc_n(5); nxt_n(1); inc_n(8);
        check();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        expect_st("tick_235959", 0, 0, 23, 59, 59, 7, 0, 0);
        drive(1'b0, 1'b0, 1'b0, 1'b1); check();
        expect_st("tick_midnight", 0, 0, 0, 0, 0, 7, 0, 0);
        drive(1'b0, 1'b0, 1'b0, 1'b1); check();

        // Hour clamp
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        expect_st("preset_19", 1, 2, 19, 0, 0, 7, 0, 0);
        inc_n(1); nxt_n(1); inc_n(9); check();
        nxt_n(5);
        expect_st("hour_tens_clamp", 1, 1, 23, 0, 0, 7, 0, 0);
        inc_n(1); check();
        expect_st("hour_ones_wrap_at_2x", 1, 2, 20, 0, 0, 7, 0, 0);
        nxt_n(1); inc_n(1); check();

        // Frozen in CLOCK_SET, running in ALARM_SET
        expect_st("clock_set_frozen", 1, 2, 20, 0, 0, 7, 0, 0);
        repeat (5) drive(1'b0, 1'b0, 1'b0, 1'b1);
        check();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        nxt_n(3);
        expect_st("alarm_set_runs_and_edits", 2, 4, 20, 0, 5, 7, 1, 0);
        repeat (4) drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        check();
        expect_st("alarm_min_ones_wrap", 2, 4, 20, 0, 5, 7, 0, 0);
        inc_n(9); check();

        // Alarm pulse with alarm_en = 1
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        expect_st("preset_065959", 1, 6, 6, 59, 59, 7, 0, 0);
        inc_n(1); nxt_n(1); inc_n(6); nxt_n(1); inc_n(5); nxt_n(1);
        inc_n(9); nxt_n(1); inc_n(5); nxt_n(1); inc_n(4);
        check();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        alarm_en = 1'b1;
        expect_st("alarm_hit_pulse", 0, 0, 7, 0, 0, 7, 0, 1);
        drive(1'b0, 1'b0, 1'b0, 1'b1); check();
        expect_st("alarm_hit_one_cycle", 0, 0, 7, 0, 0, 7, 0, 0);
        drive(1'b0, 1'b0, 1'b0, 1'b0); check();

        // Same crossing with alarm_en = 0
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        expect_st("preset_065959_again", 1, 6, 6, 59, 59, 7, 0, 0);
        nxt_n(1); inc_n(9); nxt_n(1); inc_n(5); nxt_n(1);
        inc_n(9); nxt_n(1); inc_n(5); nxt_n(1); inc_n(9);
        check();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        alarm_en = 1'b0;
        expect_st("alarm_disabled", 0, 0, 7, 0, 0, 7, 0, 0);
        drive(1'b0, 1'b0, 1'b0, 1'b1); check();
        expect_st("alarm_disabled_next", 0, 0, 7, 0, 0, 7, 0, 0);
        drive(1'b0, 1'b0, 1'b0, 1'b0); check();

        // Asynchronous reset mid-edit
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        expect_st("edit_pos3", 1, 3, 7, 10, 0, 7, 0, 0);
        nxt_n(2); inc_n(1); check();
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        expect_st("async_reset", 0, 0, 0, 0, 0, 7, 0, 0);
        check();
        @(negedge clk);
        rst_n = 1'b1;

        // Key priority
        expect_st("mode_beats_inc", 1, 1, 0, 0, 0, 7, 0, 0);
        drive(1'b1, 1'b0, 1'b1, 1'b0); check();
        expect_st("next_beats_inc", 1, 2, 0, 0, 0, 7, 0, 0);
        drive(1'b0, 1'b1, 1'b1, 1'b0); check();
        expect_st("mode_beats_next", 2, 1, 0, 0, 0, 7, 0, 0);
        drive(1'b1, 1'b1, 1'b0, 1'b0); check();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
